// File: rtl/nvme_perst_pkg.sv
// Shared types for the PERST# sequencer: FSM states, status codes and the
// state-to-output decode used by the controller's registered outputs.
package nvme_perst_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ASSERT    = 3'd1,
        SETTLE    = 3'd2,
        WAIT_LINK = 3'd3,
        HOLD      = 3'd4,
        ERROR     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE      = 2'd0,
        ST_OK        = 2'd1,
        ST_TIMEOUT   = 2'd2,
        ST_LINK_LOST = 2'd3
    } status_e;

    function automatic logic perst_level(input state_e s);
        return (s == ASSERT) || (s == HOLD);
    endfunction

    function automatic logic busy_level(input state_e s);
        return !((s == IDLE) || (s == ERROR));
    endfunction

endpackage

// File: rtl/nvme_perst_timer.sv
// 32-bit loadable down-counter shared by the timed sequencer states.
// Expire is high while the count sits at zero; the count stops there.
module nvme_perst_timer #(
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic        clk,
    input  logic        srst_i,
    input  logic        load_i,
    input  logic [31:0] value_i,
    output logic        expire_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (srst_i) begin
            count_q <= RESET_VALUE;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
        end
    end

    assign expire_o = (count_q == 32'd0);

endmodule

// File: rtl/nvme_perst_ctl.sv
// PCIe PERST# sequencer: timed PERST pulse, settle window, link wait with
// retries, hold override, sticky status and a saturating PERST edge counter.
module nvme_perst_ctl
    import nvme_perst_pkg::*;
#(
    parameter int unsigned T_ASSERT     = 32'd25000000,
    parameter int unsigned T_SETTLE     = 32'd250000,
    parameter int unsigned T_LINK       = 32'd125000000,
    parameter int unsigned MAX_RETRY    = 32'd3,
    parameter bit          AUTO_RECOVER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_reset,
    input  logic        req_hold,
    input  logic        req_clear,
    input  logic        pcie_xx_link_up,
    input  logic        pcie_xx_init_done,
    output logic        pcie_perst,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [3:0]  retry_count,
    output logic [31:0] perst_count
);

    // The timer holds (duration - 1) on entry so each state lasts exactly its duration.
    localparam logic [31:0] LD_ASSERT = 32'(T_ASSERT - 32'd1);
    localparam logic [31:0] LD_SETTLE = 32'(T_SETTLE - 32'd1);
    localparam logic [31:0] LD_LINK   = 32'(T_LINK - 32'd1);

    state_e      state_q, state_d;
    status_e     status_q, status_d;
    logic [3:0]  retry_q, retry_d;
    logic        perst_q, perst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] perst_cnt_q;
    logic        link_q;
    logic        link_fall;
    logic        tmr_load;
    logic [31:0] tmr_value;
    logic        tmr_expire;

    nvme_perst_timer #(
        .RESET_VALUE(LD_ASSERT)
    ) u_timer (
        .clk     (clk),
        .srst_i  (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .expire_o(tmr_expire)
    );

    assign link_fall = link_q && !pcie_xx_link_up;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        retry_d   = retry_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = 32'd0;
        if (req_hold) begin
            state_d = HOLD;
            retry_d = 4'd0;
        end else begin
            if (req_clear && (status_q == ST_LINK_LOST) && (state_q != ERROR)) begin
                status_d = ST_NONE;
            end
            case (state_q)
                IDLE: begin
                    if ((status_q == ST_OK) && link_fall) begin
                        status_d = ST_LINK_LOST;
                    end
                    if (req_reset || (AUTO_RECOVER && (status_q == ST_OK) && link_fall)) begin
                        state_d   = ASSERT;
                        retry_d   = 4'd0;
                        tmr_load  = 1'b1;
                        tmr_value = LD_ASSERT;
                    end
                end
                ASSERT: begin
                    if (tmr_expire) begin
                        state_d   = SETTLE;
                        tmr_load  = 1'b1;
                        tmr_value = LD_SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_expire) begin
                        state_d   = WAIT_LINK;
                        tmr_load  = 1'b1;
                        tmr_value = LD_LINK;
                    end
                end
                WAIT_LINK: begin
                    // Success is tested first so it wins over a coincident expiry.
                    if (pcie_xx_link_up && pcie_xx_init_done) begin
                        state_d  = IDLE;
                        status_d = ST_OK;
                        done_d   = 1'b1;
                    end else if (tmr_expire) begin
                        if ({28'd0, retry_q} < MAX_RETRY) begin
                            state_d   = ASSERT;
                            retry_d   = retry_q + 4'd1;
                            tmr_load  = 1'b1;
                            tmr_value = LD_ASSERT;
                        end else begin
                            state_d  = ERROR;
                            status_d = ST_TIMEOUT;
                            done_d   = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state_d   = SETTLE;
                    tmr_load  = 1'b1;
                    tmr_value = LD_SETTLE;
                end
                ERROR: begin
                    if (req_clear) begin
                        state_d  = IDLE;
                        status_d = ST_NONE;
                        retry_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        perst_d = perst_level(state_d);
        busy_d  = busy_level(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ASSERT;
            status_q    <= ST_NONE;
            retry_q     <= 4'd0;
            perst_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            perst_cnt_q <= 32'd1;
            link_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            retry_q  <= retry_d;
            perst_q  <= perst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            link_q   <= pcie_xx_link_up;
            if (perst_d && !perst_q && (perst_cnt_q != 32'hFFFF_FFFF)) begin
                perst_cnt_q <= perst_cnt_q + 32'd1;
            end
        end
    end

    assign pcie_perst  = perst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign retry_count = retry_q;
    assign perst_count = perst_cnt_q;

endmodule

// File: tb/tb_nvme_perst_ctl.sv
// Scenario bench for nvme_perst_ctl: a scoreboard of expected done events for
// the main instance plus direct checks; a second instance has auto-recovery on.
module tb_nvme_perst_ctl;

    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_OK   = 2'd1;
    localparam logic [1:0] S_TMO  = 2'd2;
    localparam logic [1:0] S_LOST = 2'd3;

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [3:0]  rc;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, req_reset, req_hold, req_clear, link_up, init_done;
    logic perst0, busy0, done0, perst1, busy1, done1;
    logic [1:0]  status0, status1;
    logic [3:0]  retry0, retry1;
    logic [31:0] pcnt0, pcnt1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nvme_perst_ctl #(
        .T_ASSERT(8), .T_SETTLE(4), .T_LINK(32), .MAX_RETRY(2), .AUTO_RECOVER(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .req_reset(req_reset), .req_hold(req_hold),
        .req_clear(req_clear), .pcie_xx_link_up(link_up), .pcie_xx_init_done(init_done),
        .pcie_perst(perst0), .busy(busy0), .done(done0), .status(status0),
        .retry_count(retry0), .perst_count(pcnt0)
    );

    nvme_perst_ctl #(
        .T_ASSERT(8), .T_SETTLE(4), .T_LINK(32), .MAX_RETRY(2), .AUTO_RECOVER(1'b1)
    ) dut_ar (
        .clk(clk), .reset(reset), .req_reset(req_reset), .req_hold(req_hold),
        .req_clear(req_clear), .pcie_xx_link_up(link_up), .pcie_xx_init_done(init_done),
        .pcie_perst(perst1), .busy(busy1), .done(done1), .status(status1),
        .retry_count(retry1), .perst_count(pcnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_req(output int e);
        req_reset = 1'b1;
        @(negedge clk);
        req_reset = 1'b0;
        e = cyc;
    endtask

    task automatic push(input int c, input logic [1:0] st, input logic [3:0] rc, input logic [31:0] pc);
        exp_t x;
        x.cyc = c; x.st = st; x.rc = rc; x.pc = pc;
        sb_q.push_back(x);
    endtask

    // One line per completed sequence on the main instance.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            $display("done @%0d status=%0d retry=%0d perst_count=%0d", cyc, status0, retry0, pcnt0);
            chk("sb_nonempty", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                got = sb_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(got.cyc));
                chk("done_status", status0, got.st);
                chk("done_retry", retry0, got.rc);
                chk("done_pcount", pcnt0, got.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int e, r, c, x, bad_hold;
        bit seen;
        reset = 1'b1; req_reset = 1'b0; req_hold = 1'b0; req_clear = 1'b0;
        link_up = 1'b1; init_done = 1'b1;

        // Power-on sequence with link already up
        repeat (3) @(negedge clk);
        chk("rst_perst", perst0, 1);
        chk("rst_busy", busy0, 1);
        chk("rst_done", done0, 0);
        chk("rst_status", status0, S_NONE);
        chk("rst_retry", retry0, 0);
        chk("rst_pcount", pcnt0, 1);
        reset = 1'b0;
        r = cyc;
        push(r + 13, S_OK, 0, 1);
        wait_cyc(r + 7);  chk("po_perst_last", perst0, 1);
        wait_cyc(r + 8);  chk("po_perst_off", perst0, 0);
        wait_cyc(r + 16);

        // Software reset, link returns late
        pulse_req(e);
        link_up = 1'b0;
        push(e + 20, S_OK, 0, 2);
        chk("sw_perst_first", perst0, 1);
        chk("sw_busy", busy0, 1);
        wait_cyc(e + 7);  chk("sw_perst_last", perst0, 1);
        wait_cyc(e + 8);  chk("sw_perst_off", perst0, 0);
        wait_cyc(e + 19); link_up = 1'b1;
        wait_cyc(e + 22);

        // Link never comes up: two retries then ERROR
        pulse_req(e);
        link_up = 1'b0;
        push(e + 132, S_TMO, 2, 5);
        wait_cyc(e + 44);
        chk("to_retry_perst", perst0, 1);
        chk("to_retry1", retry0, 1);
        wait_cyc(e + 133);
        chk("err_busy", busy0, 0);
        chk("err_perst", perst0, 0);
        pulse_req(x);
        wait_cyc(x + 2);
        chk("err_ignore_req_busy", busy0, 0);
        chk("err_ignore_req_status", status0, S_TMO);
        req_clear = 1'b1;
        @(negedge clk);
        req_clear = 1'b0;
        chk("clr_status", status0, S_NONE);
        chk("clr_retry", retry0, 0);
        chk("clr_busy", busy0, 0);

        // Hold raised mid-WAIT_LINK for 50 cycles, link returns during hold
        pulse_req(e);
        push(e + 75, S_OK, 0, 7);
        wait_cyc(e + 19);
        req_hold = 1'b1;
        bad_hold = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (perst0 !== 1'b1 || busy0 !== 1'b1) bad_hold++;
            req_reset = (i == 10) || (i == 30);
            if (i == 40) link_up = 1'b1;
        end
        req_reset = 1'b0;
        req_hold = 1'b0;
        chk("hold_perst_cycles_bad", 64'(bad_hold), 0);
        wait_cyc(e + 70);
        chk("hold_rel_perst", perst0, 0);
        chk("hold_rel_busy", busy0, 1);
        wait_cyc(e + 78);

        // Success on the very last WAIT_LINK cycle
        pulse_req(e);
        link_up = 1'b0;
        push(e + 44, S_OK, 0, 8);
        wait_cyc(e + 43); link_up = 1'b1;
        wait_cyc(e + 46);
        chk("coinc_perst", perst0, 0);

        // Reset during SETTLE restarts a full PERST pulse
        pulse_req(e);
        wait_cyc(e + 9);
        chk("mid_settle_perst", perst0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_perst", perst0, 1);
        chk("mid_rst_pcount", pcnt0, 1);
        reset = 1'b0;
        r = cyc;
        push(r + 13, S_OK, 0, 1);
        wait_cyc(r + 7);  chk("re_perst_last", perst0, 1);
        wait_cyc(r + 8);  chk("re_perst_off", perst0, 0);
        wait_cyc(r + 16);

        // Link loss in IDLE after OK
        c = cyc;
        link_up = 1'b0;
        @(negedge clk);
        chk("ll_status", status0, S_LOST);
        chk("ll_perst", perst0, 0);
        chk("ll_busy", busy0, 0);
        chk("ll_pcount", pcnt0, 1);
        chk("ar_perst", perst1, 1);
        chk("ar_status", status1, S_LOST);
        chk("ar_pcount", pcnt1, 2);
        req_clear = 1'b1;
        @(negedge clk);
        req_clear = 1'b0;
        link_up = 1'b1;
        chk("ll_clear_status", status0, S_NONE);
        wait_cyc(c + 8);  chk("ar_perst_last", perst1, 1);
        wait_cyc(c + 9);  chk("ar_perst_off", perst1, 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done1 === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("ar_done_seen", 64'(seen), 1);
        if (seen) begin
            chk("ar_done_cycle", 64'(cyc), 64'(c + 14));
            chk("ar_done_status", status1, S_OK);
            chk("ar_done_retry", retry1, 0);
        end
        repeat (4) @(negedge clk);

        chk("sb_drain", 64'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nvme_perst_ctl.md
# nvme_perst_ctl

Production PCIe fundamental-reset (PERST#) sequencer for the NVMe AFU. It sits between the MMIO register block and the PCIe hard-IP wrapper. It converts software reset requests into a timed PERST pulse, waits for link training and init to complete, retries on timeout, and reports status and counters back to MMIO. At power-on it runs one sequence autonomously.

## Interface
Parameters:
- T_ASSERT, 25000000: PERST assertion width in clk cycles (100 ms at 4 ns).
- T_SETTLE, 250000: cycles after PERST release during which link_up is ignored.
- T_LINK, 125000000: cycles allowed in WAIT_LINK for link_up & init_done.
- MAX_RETRY, 3: retries after the first attempt before entering ERROR.
- AUTO_RECOVER, 0: 1 means a link loss in IDLE automatically starts a new sequence.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- req_reset  in  1  one-cycle pulse from MMIO; starts a sequence.
- req_hold  in  1  level from MMIO; holds PERST asserted while high.
- req_clear  in  1  one-cycle pulse; leaves ERROR and clears sticky status.
- pcie_xx_link_up  in  1  PCIe link up.
- pcie_xx_init_done  in  1  PCIe init complete.
- pcie_perst  out  1  PERST to PCIe wrapper (1 = asserted), registered.
- busy  out  1  high in any state except IDLE and ERROR.
- done  out  1  one-cycle pulse when a sequence ends in IDLE or ERROR.
- status  out  2  0 NONE, 1 OK, 2 TIMEOUT, 3 LINK_LOST.
- retry_count  out  4  retries used in the current or last sequence.
- perst_count  out  32  PERST rising edges since reset; saturates at 0xFFFFFFFF.

## Operation
- States and transitions:
  - IDLE: leaves on req_reset → ASSERT.
  - ASSERT: pcie_perst=1 for exactly T_ASSERT cycles, then → SETTLE.
  - SETTLE: T_SETTLE cycles, then → WAIT_LINK.
  - WAIT_LINK: success → IDLE; timeout → ASSERT or ERROR (see below).
  - HOLD: entered while req_hold is high.
  - ERROR: pcie_perst=0; waits for req_clear.
- req_hold=1 sends any state to HOLD next cycle, with pcie_perst=1 and retry_count reset to 0. When req_hold falls → SETTLE. req_hold has priority over every other input.
- WAIT_LINK success: link_up & init_done both high in one sampled cycle. Result: → IDLE, status=OK, done pulse.
- WAIT_LINK timeout: T_LINK cycles elapse without success.
  - If retry_count < MAX_RETRY: retry_count+1, → ASSERT.
  - Otherwise: → ERROR, status=TIMEOUT, done pulse.
- Success and timeout in the same cycle: success wins.
- req_reset while busy: ignored. In ERROR: ignored; only req_clear acts, giving → IDLE, status=NONE, retry_count=0.
- req_clear outside ERROR: clears LINK_LOST to NONE. No effect otherwise.
- IDLE with status=OK and link_up falling: status=LINK_LOST (sticky).
  - If AUTO_RECOVER=1, also → ASSERT on the following cycle, with retry_count cleared.
- Entry to ASSERT from IDLE clears retry_count.
- perst_count increments on every 0→1 transition of pcie_perst, including the power-on sequence.

## Timing
- Reset values:
  - state ASSERT, pcie_perst=1, busy=1, done=0, status=NONE, retry_count=0, perst_count=1.
  - The reset assertion is itself counted as one edge.
- Reset at any point aborts the current sequence and restarts it from ASSERT with a full T_ASSERT.
- req_reset sampled at cycle N: pcie_perst=1 from N+1 through N+T_ASSERT; pcie_perst=0 at N+T_ASSERT+1.
- WAIT_LINK is entered T_SETTLE cycles after pcie_perst falls. Link inputs high during SETTLE are ignored.
- done rises in the cycle after the deciding sample, in the same cycle the new status becomes visible.
- Timers are 32-bit. All parameters must be ≥1 and < 2^32.

## Structure
- Package nvme_perst_pkg holds:
  - state enum (IDLE, ASSERT, SETTLE, WAIT_LINK, HOLD, ERROR);
  - status codes (ST_NONE, ST_OK, ST_TIMEOUT, ST_LINK_LOST).
- Sub-module nvme_perst_timer: a 32-bit loadable down-counter with load, value and expire, shared by ASSERT, SETTLE and WAIT_LINK.

## Test plan
All scenarios use T_ASSERT=8, T_SETTLE=4, T_LINK=32, MAX_RETRY=2.
- Power-on: release reset with link inputs held high → pcie_perst high 8 cycles, done 13 cycles later, status=OK, perst_count=1.
- req_reset at cycle N with link up at N+20 → pcie_perst high N+1..N+8, done at N+21, status=OK, retry_count=0, perst_count=2.
- Link never comes up → 3 PERST pulses, done after the third timeout, status=TIMEOUT, retry_count=2. Then req_clear → IDLE, status=NONE.
- req_hold raised mid-WAIT_LINK for 50 cycles → pcie_perst=1 throughout. On release: SETTLE, then success. Extra req_reset pulses during hold are ignored.
- After OK, drop link_up:
  - AUTO_RECOVER=0 → status=LINK_LOST, no PERST.
  - AUTO_RECOVER=1 → PERST pulse next cycle and a new sequence.
- Success coincident with timeout expiry → status=OK, no retry. Reset asserted mid-SETTLE → a full 8-cycle PERST restarts.
